// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Single-cycle registered ALU with carry/borrow and zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_A,
    input  logic [NB_DATA-1:0] i_B,
    input  logic [NB_OP-1:0]   i_OP,
    output logic [NB_DATA-1:0] o_led,
    output logic               o_carry,
    output logic               o_zero
);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    localparam logic [NB_DATA:0] C_WIDTH = (NB_DATA+1)'(NB_DATA);

    logic [NB_DATA:0]   w_sum;
    logic [NB_DATA:0]   w_diff;
    logic               w_shift_sat;
    logic [NB_DATA-1:0] w_srl;
    logic [NB_DATA-1:0] w_sra;

    logic [NB_DATA-1:0] result_d, result_q;
    logic               carry_d,  carry_q;
    logic               zero_d,   zero_q;

    // The extra top bit carries the add carry-out / subtract borrow.
    assign w_sum  = {1'b0, i_A} + {1'b0, i_B};
    assign w_diff = {1'b0, i_A} - {1'b0, i_B};

    assign w_shift_sat = ({1'b0, i_B} >= C_WIDTH);
    assign w_srl = w_shift_sat ? '0 : (i_A >> i_B);
    assign w_sra = w_shift_sat ? {NB_DATA{i_A[NB_DATA-1]}}
                               : NB_DATA'($signed(i_A) >>> i_B);

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (i_OP)
            OP_ADD: begin
                result_d = w_sum[NB_DATA-1:0];
                carry_d  = w_sum[NB_DATA];
            end
            OP_SUB: begin
                result_d = w_diff[NB_DATA-1:0];
                carry_d  = w_diff[NB_DATA];
            end
            OP_AND:  result_d = i_A & i_B;
            OP_OR:   result_d = i_A | i_B;
            OP_XOR:  result_d = i_A ^ i_B;
            OP_NOR:  result_d = ~(i_A | i_B);
            OP_SRA:  result_d = w_sra;
            OP_SRL:  result_d = w_srl;
            default: begin
                result_d = '0;
                carry_d  = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign o_led   = result_q;
    assign o_carry = carry_q;
    assign o_zero  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Directed and randomized checks of alu against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int NB = 8;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] A;
    logic [NB-1:0] B;
    logic [5:0]    OP;
    logic [NB-1:0] led;
    logic          carry;
    logic          zero;

    int checks   = 0;
    int failures = 0;

    alu #(.NB_DATA(NB), .NB_OP(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_A     (A),
        .i_B     (B),
        .i_OP    (OP),
        .o_led   (led),
        .o_carry (carry),
        .o_zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ADD = 32, SUB = 34, AND_ = 36, OR_ = 37, XOR_ = 38, NOR_ = 39;
    localparam int SRA = 3,  SRL = 2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the arithmetic rules, on plain integers.
    function automatic void model(input int a, input int b, input int op,
                                  output int res, output int cy);
        int sa;
        res = 0;
        cy  = 0;
        sa  = (a >= 128) ? a - 256 : a;
        case (op)
            ADD:  begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
            SUB:  begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            AND_: res = a & b;
            OR_:  res = a | b;
            XOR_: res = a ^ b;
            NOR_: res = 255 - (a | b);
            SRL:  res = (b >= NB) ? 0 : (a >> b);
            SRA:  res = (b >= NB) ? ((a >= 128) ? 255 : 0) : ((sa >>> b) & 255);
            default: begin res = 0; cy = 0; end
        endcase
    endfunction

    task automatic step(input int a, input int b, input int op);
        @(negedge clk);
        A  = NB'(a);
        B  = NB'(b);
        OP = 6'(op);
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int r, input int c, input int z);
        chk({tag, "_led"},   32'(led),   32'(r));
        chk({tag, "_carry"}, 32'(carry), 32'(c));
        chk({tag, "_zero"},  32'(zero),  32'(z));
    endtask

    initial begin
        int ops[8] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRA, SRL};
        int a, b, op, er, ec;

        rst_n = 1'b0;
        A = '0; B = '0; OP = '0;
        #1;
        expect3("reset_init", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(8'h7F, 8'h01, ADD);  expect3("add_7f_01", 8'h80, 0, 0);
        step(8'hFF, 8'h01, ADD);  expect3("add_ff_01", 8'h00, 1, 1);
        step(8'h05, 8'h07, SUB);  expect3("sub_05_07", 8'hFE, 1, 0);
        step(8'h07, 8'h07, SUB);  expect3("sub_07_07", 8'h00, 0, 1);
        step(8'hF0, 8'h3C, AND_); expect3("and",       8'h30, 0, 0);
        step(8'hF0, 8'h3C, OR_);  expect3("or",        8'hFC, 0, 0);
        step(8'hF0, 8'h3C, XOR_); expect3("xor",       8'hCC, 0, 0);
        step(8'h0F, 8'hF0, NOR_); expect3("nor",       8'h00, 0, 1);
        step(8'h80, 2,     SRA);  expect3("sra_2",     8'hE0, 0, 0);
        step(8'h80, 2,     SRL);  expect3("srl_2",     8'h20, 0, 0);
        step(8'h80, 9,     SRL);  expect3("srl_9",     8'h00, 0, 1);
        step(8'h80, 9,     SRA);  expect3("sra_9",     8'hFF, 0, 0);
        step(8'h5A, 0,     SRL);  expect3("srl_0",     8'h5A, 0, 0);
        step(8'h12, 8'h34, 63);   expect3("op_3f",     8'h00, 0, 1);

        // Reset asserted between edges right after a carrying add.
        step(8'hFF, 8'h01, ADD);  expect3("pre_rst",   8'h00, 1, 1);
        step(8'h7F, 8'h01, ADD);  expect3("pre_rst2",  8'h80, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect3("rst_async", 0, 0, 0);
        @(posedge clk);
        #1;
        expect3("rst_hold", 0, 0, 0);
        @(negedge clk);
        A = 8'hF0; B = 8'h3C; OP = 6'(AND_);
        rst_n = 1'b1;
        #1;
        expect3("rst_release_pre_edge", 0, 0, 0);
        @(posedge clk);
        #1;
        expect3("rst_release", 8'h30, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 7)];
            else                          op = int'($urandom_range(0, 63));
            a = int'($urandom_range(0, 255));
            if ((op == SRA || op == SRL) && $urandom_range(0, 1) == 1)
                b = int'($urandom_range(0, 12));
            else
                b = int'($urandom_range(0, 255));
            model(a, b, op, er, ec);
            step(a, b, op);
            expect3($sformatf("rand%0d_op%0d_a%0h_b%0h", i, op, a, b), er, ec, (er == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
